// File: rtl/cvt12_cfu_if.sv
// CFU-L2 request/response bus plus the forwarded CFU-L1 subordinate port.
// slave  : the adapter side (takes L2 requests, drives the L1 target).
// master : the side that issues L2 requests and models the L1 target.
// Field widths come from the CFU parameters; zero-width fields collapse
// to a single bit so that every port remains legal.
interface cvt12_cfu_if #(
  parameter int CFU_N_CFUS    = 1,
  parameter int CFU_FUNC_ID_W = 0,
  parameter int CFU_INSN_W    = 0,
  parameter int CFU_DATA_W    = 32
);
  localparam int CFU_ID_W = (CFU_N_CFUS > 1) ? $clog2(CFU_N_CFUS) : 1;
  localparam int STATE_W  = 1;
  localparam int FUNC_W   = (CFU_FUNC_ID_W > 0) ? CFU_FUNC_ID_W : 1;
  localparam int INSN_W   = (CFU_INSN_W > 0) ? CFU_INSN_W : 1;
  localparam int STATUS_W = 3;

  // L2 request
  logic                  req_valid;
  logic                  req_ready;
  logic [CFU_ID_W-1:0]   req_cfu;
  logic [STATE_W-1:0]    req_state;
  logic [FUNC_W-1:0]     req_func;
  logic [INSN_W-1:0]     req_insn;
  logic [CFU_DATA_W-1:0] req_data0;
  logic [CFU_DATA_W-1:0] req_data1;
  // L2 response
  logic                  resp_valid;
  logic                  resp_ready;
  logic [STATUS_W-1:0]   resp_status;
  logic [CFU_DATA_W-1:0] resp_data;
  // L1 subordinate
  logic                  t_req_valid;
  logic [CFU_ID_W-1:0]   t_req_cfu;
  logic [FUNC_W-1:0]     t_req_func;
  logic [CFU_DATA_W-1:0] t_req_data0;
  logic [CFU_DATA_W-1:0] t_req_data1;
  logic                  t_resp_valid;
  logic [STATUS_W-1:0]   t_resp_status;
  logic [CFU_DATA_W-1:0] t_resp_data;

  modport slave (
    input  req_valid, req_cfu, req_state, req_func, req_insn, req_data0, req_data1,
    output req_ready,
    output resp_valid, resp_status, resp_data,
    input  resp_ready,
    output t_req_valid, t_req_cfu, t_req_func, t_req_data0, t_req_data1,
    input  t_resp_valid, t_resp_status, t_resp_data
  );

  modport master (
    output req_valid, req_cfu, req_state, req_func, req_insn, req_data0, req_data1,
    input  req_ready,
    input  resp_valid, resp_status, resp_data,
    output resp_ready,
    input  t_req_valid, t_req_cfu, t_req_func, t_req_data0, t_req_data1,
    output t_resp_valid, t_resp_status, t_resp_data
  );
endinterface

// File: rtl/cvt12_cfu.sv
// cvt12_cfu: CFU-L2 front end for a fixed-latency pipelined CFU-L1 target.
// Requests are forwarded to the target as soon as a credit is available;
// target responses land in a FIFO_DEPTH-entry queue drained under L2
// resp_ready. A credit counter (in-flight + queued) guarantees the queue
// never overflows, because the L1 target cannot be stalled.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clk_en     clock enable shared with the target; low freezes all state
//   bus        cvt12_cfu_if.slave: L2 req/resp and forwarded L1 target port
module cvt12_cfu #(
  parameter int CFU_N_CFUS    = 1,
  parameter int CFU_N_STATES  = 0,
  parameter int CFU_FUNC_ID_W = 0,
  parameter int CFU_INSN_W    = 0,
  parameter int CFU_DATA_W    = 32,
  parameter int CFU_LATENCY   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  cvt12_cfu_if.slave  bus
);
  localparam int STATUS_W = 3;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  if (CFU_N_STATES != 0) begin : g_bad_states
    $error("cvt12_cfu: CFU_N_STATES must be 0");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("cvt12_cfu: FIFO_DEPTH must be >= 1");
  end
  if (CFU_LATENCY < 0) begin : g_bad_lat
    $error("cvt12_cfu: CFU_LATENCY must be >= 0");
  end

  typedef struct packed {
    logic [STATUS_W-1:0]   status;
    logic [CFU_DATA_W-1:0] data;
  } entry_t;

  logic [CNT_W-1:0] cnt;   // credits in use: in flight + queued
  logic [CNT_W-1:0] occ;   // queue occupancy
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  entry_t           mem [FIFO_DEPTH];
  logic             accept, push, pop;

  // Wrap explicitly so non-power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // req_ready sees only registered cnt, rst and clk_en: no path from resp_ready.
  assign bus.req_ready   = !rst && clk_en && (cnt < DEPTH_C);
  assign accept          = bus.req_valid && bus.req_ready;

  assign bus.t_req_valid = accept;
  assign bus.t_req_cfu   = bus.req_cfu;
  assign bus.t_req_func  = bus.req_func;
  assign bus.t_req_data0 = bus.req_data0;
  assign bus.t_req_data1 = bus.req_data1;

  // Gated by rst so that nothing queued is visible during the reset cycle.
  assign bus.resp_valid  = !rst && (occ != '0);
  assign bus.resp_status = mem[rd_ptr].status;
  assign bus.resp_data   = mem[rd_ptr].data;

  assign push = bus.t_resp_valid && clk_en;
  assign pop  = bus.resp_valid && bus.resp_ready && clk_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (accept && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!accept && pop) cnt <= cnt - CNT_W'(1);
      if (push && !pop)        occ <= occ + CNT_W'(1);
      else if (!push && pop)   occ <= occ - CNT_W'(1);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{status: bus.t_resp_status, data: bus.t_resp_data};
  end

  // Shadow of the target pipeline: vld_pipe[k] is an accept from k cycles ago.
  logic [CFU_LATENCY:0] vld_pipe;
  if (CFU_LATENCY > 0) begin : g_shadow
    logic [CFU_LATENCY-1:0] sh_q;
    assign vld_pipe = {sh_q, bus.t_req_valid};
    always_ff @(posedge clk) begin
      if (rst)         sh_q <= '0;
      else if (clk_en) sh_q <= vld_pipe[CFU_LATENCY-1:0];
    end
  end else begin : g_no_shadow
    assign vld_pipe = bus.t_req_valid;
  end

  logic unused_ok;
  assign unused_ok = ^{bus.req_state, bus.req_insn};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      assert (bus.t_resp_valid == vld_pipe[CFU_LATENCY])
        else $error("cvt12_cfu: target response does not match CFU_LATENCY");
  end
`endif
endmodule
